// File: rtl/ym6046_pkg.sv
// Shared definitions for the YM6046 serial block: oversample default and
// the receive/transmit frame state encoding.
package ym6046_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ym6046_state_e;

endpackage

// File: rtl/ym6046_sync2.sv
// Two-flop synchronizer for the asynchronous serial pin; resets to the
// line-idle level (1) so reset release never looks like a start bit.
module ym6046_sync2 (
  input  logic MCLK,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ym6046_uart_rx.sv
// YM6046 UART receiver: 8N1 oversampled frame capture with ready/error
// flags, overrun detection and a registered receive interrupt.
module ym6046_uart_rx
  import ym6046_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       rx_tick,
  input  logic       rx_enable,
  input  logic       rxd,
  input  logic       read_rx_data,
  input  logic       rx_int_en,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_error,
  output logic       irq_rx
);

  localparam int unsigned   TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

  logic          rxs;
  ym6046_state_e state, state_next;
  logic [TW-1:0] tick_cnt, tick_cnt_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shifter, shifter_next;
  logic [7:0]    rx_data_next;
  logic          rx_ready_next, rx_error_next;
  logic          frame_done;

  ym6046_sync2 u_sync (
    .MCLK  (MCLK),
    .reset (reset),
    .d     (rxd),
    .q     (rxs)
  );

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shifter_next  = shifter;
    frame_done    = 1'b0;
    if (!rx_enable) begin
      state_next    = IDLE;
      tick_cnt_next = '0;
      bit_cnt_next  = '0;
    end else if (rx_tick) begin
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state_next    = START;
            tick_cnt_next = '0;
          end
        end
        START: begin
          // Half a bit in: a line that went high again was only a glitch.
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = rxs ? IDLE : DATA;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_next = '0;
            shifter_next  = {rxs, shifter[7:1]};
            bit_cnt_next  = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state_next = STOP;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_next = '0;
            state_next    = IDLE;
            frame_done    = 1'b1;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A read landing on the completion edge frees the holding register, so
  // the new byte is accepted rather than flagged as an overrun.
  always_comb begin
    rx_data_next  = rx_data;
    rx_ready_next = rx_ready;
    rx_error_next = rx_error;
    if (frame_done) begin
      if (!rx_ready || read_rx_data) begin
        rx_data_next  = shifter;
        rx_ready_next = 1'b1;
        rx_error_next = ~rxs;
      end else begin
        rx_error_next = 1'b1;
      end
    end else if (read_rx_data) begin
      rx_ready_next = 1'b0;
      rx_error_next = 1'b0;
    end
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      rx_data  <= 8'h00;
      rx_ready <= 1'b0;
      rx_error <= 1'b0;
      irq_rx   <= 1'b0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_cnt  <= bit_cnt_next;
      shifter  <= shifter_next;
      rx_data  <= rx_data_next;
      rx_ready <= rx_ready_next;
      rx_error <= rx_error_next;
      irq_rx   <= rx_ready_next & rx_int_en;
    end
  end

endmodule

// File: tb/tb_ym6046_uart_rx.sv
// Self-checking bench for ym6046_uart_rx: fixed frame table, hand-written
// corner sequences and random frames against a flag-level reference model.
module tb_ym6046_uart_rx;

  localparam int unsigned OS = 16;

  logic       MCLK = 1'b0;
  logic       reset, rx_tick, rx_enable, rxd, read_rx_data, rx_int_en;
  logic [7:0] rx_data;
  logic       rx_ready, rx_error, irq_rx;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_data;
  logic       m_ready, m_error;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       rb;
    logic       rd;
    logic       ie;
    logic       exp_pre;
    logic [7:0] exp_data;
    logic       exp_ready;
    logic       exp_error;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[8];

  ym6046_uart_rx #(.OVERSAMPLE(OS)) dut (
    .MCLK         (MCLK),
    .reset        (reset),
    .rx_tick      (rx_tick),
    .rx_enable    (rx_enable),
    .rxd          (rxd),
    .read_rx_data (read_rx_data),
    .rx_int_en    (rx_int_en),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_error     (rx_error),
    .irq_rx       (irq_rx)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (3) @(negedge MCLK);
      rx_tick = 1'b1;
      @(negedge MCLK);
      rx_tick = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk8({tag, " data"}, rx_data, m_data);
    chk1({tag, " ready"}, rx_ready, m_ready);
    chk1({tag, " error"}, rx_error, m_error);
    chk1({tag, " irq"}, irq_rx, m_ready & rx_int_en);
  endtask

  task automatic wait_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge MCLK);
      while (rx_tick !== 1'b1) @(posedge MCLK);
    end
  endtask

  task automatic drive_bit(input logic v);
    @(negedge MCLK);
    rxd = v;
    wait_ticks(OS);
  endtask

  task automatic read_pulse();
    @(negedge MCLK);
    read_rx_data = 1'b1;
    @(negedge MCLK);
    read_rx_data = 1'b0;
  endtask

  task automatic model_read();
    m_ready = 1'b0;
    m_error = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop, input logic rd);
    if (!m_ready || rd) begin
      m_data  = b;
      m_ready = 1'b1;
      m_error = !stop;
    end else begin
      m_error = 1'b1;
    end
  endtask

  // Completion falls on the 153rd tick after the start bit is driven.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_done,
                            output logic pre_ready);
    wait_ticks(1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    @(negedge MCLK);
    rxd = stop;
    wait_ticks(8);
    @(negedge MCLK);
    #1;
    pre_ready = rx_ready;
    while (rx_tick !== 1'b1) begin
      @(negedge MCLK);
      #1;
    end
    read_rx_data = rd_done;
    @(posedge MCLK);
    @(negedge MCLK);
    read_rx_data = 1'b0;
    rxd = 1'b1;
    wait_ticks(7);
    @(negedge MCLK);
  endtask

  initial begin
    logic       pre;
    logic [7:0] b;
    logic       s, rb, rd;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1};

    reset        = 1'b0;
    rx_enable    = 1'b1;
    rxd          = 1'b1;
    read_rx_data = 1'b0;
    rx_int_en    = 1'b1;
    m_data       = 8'h00;
    m_ready      = 1'b0;
    m_error      = 1'b0;

    repeat (4) @(negedge MCLK);
    chk8("reset data", rx_data, 8'h00);
    chk1("reset ready", rx_ready, 1'b0);
    chk1("reset error", rx_error, 1'b0);
    chk1("reset irq", irq_rx, 1'b0);
    reset = 1'b1;
    wait_ticks(4);

    for (int i = 0; i < 8; i++) begin
      @(negedge MCLK);
      rx_int_en = vecs[i].ie;
      if (vecs[i].rb) begin
        read_pulse();
        model_read();
      end
      send_frame(vecs[i].b, vecs[i].stop, vecs[i].rd, pre);
      model_frame(vecs[i].b, vecs[i].stop, vecs[i].rd);
      chk1($sformatf("vec%0d pre-completion ready", i), pre, vecs[i].exp_pre);
      chk8($sformatf("vec%0d data", i), rx_data, vecs[i].exp_data);
      chk1($sformatf("vec%0d ready", i), rx_ready, vecs[i].exp_ready);
      chk1($sformatf("vec%0d error", i), rx_error, vecs[i].exp_error);
      chk1($sformatf("vec%0d irq", i), irq_rx, vecs[i].exp_irq);
    end

    read_pulse();
    model_read();
    @(negedge MCLK);
    chk8("read clear data holds", rx_data, 8'h0F);
    chk1("read clear ready", rx_ready, 1'b0);
    chk1("read clear error", rx_error, 1'b0);
    chk1("read clear irq", irq_rx, 1'b0);

    rx_int_en = 1'b1;
    wait_ticks(1);
    @(negedge MCLK);
    rxd = 1'b0;
    wait_ticks(4);
    @(negedge MCLK);
    rxd = 1'b1;
    wait_ticks(32);
    @(negedge MCLK);
    check_model("glitch");
    send_frame(8'h5A, 1'b1, 1'b0, pre);
    model_frame(8'h5A, 1'b1, 1'b0);
    chk1("after glitch pre ready", pre, 1'b0);
    check_model("after glitch 5A");

    send_frame(8'h99, 1'b1, 1'b0, pre);
    model_frame(8'h99, 1'b1, 1'b0);
    check_model("overrun 99");
    wait_ticks(1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    @(negedge MCLK);
    rxd = 1'b1;
    wait_ticks(8);
    @(negedge MCLK);
    reset = 1'b0;
    repeat (3) @(negedge MCLK);
    reset = 1'b1;
    m_data = 8'h00;
    m_ready = 1'b0;
    m_error = 1'b0;
    wait_ticks(200);
    @(negedge MCLK);
    check_model("mid-frame reset");
    send_frame(8'hC3, 1'b1, 1'b0, pre);
    model_frame(8'hC3, 1'b1, 1'b0);
    check_model("after reset C3");

    read_pulse();
    model_read();
    wait_ticks(1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    @(negedge MCLK);
    rx_enable = 1'b0;
    rxd = 1'b1;
    wait_ticks(5);
    @(negedge MCLK);
    rx_enable = 1'b1;
    wait_ticks(200);
    @(negedge MCLK);
    check_model("disable mid-frame");

    for (int n = 0; n < 24; n++) begin
      wait_ticks($urandom_range(0, 20));
      @(negedge MCLK);
      rx_int_en = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      s  = ($urandom_range(0, 3) != 0);
      rb = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 4) == 0);
      if (rb) begin
        read_pulse();
        model_read();
      end
      send_frame(b, s, rd, pre);
      chk1($sformatf("rand%0d pre ready", n), pre, m_ready);
      model_frame(b, s, rd);
      check_model($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
